// File: rtl/doom_pal_writer_if.sv
// rtl/doom_pal_writer_if.sv - palette load, indexed pixel stream and Avalon-MM pixel bus bundle
interface doom_pal_writer_if;
    logic        pal_we;
    logic [7:0]  pal_idx;
    logic [23:0] pal_rgb;

    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_index;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        pix_last;

    logic [31:0] vga_address;
    logic        vga_write;
    logic [15:0] vga_writedata;
    logic        vga_waitrequest;

    // master: the frame-update engine and VGA slave environment; slave: the writer itself
    modport master (
        output pal_we, pal_idx, pal_rgb,
        output pix_valid, pix_index, pix_x, pix_y, pix_last,
        input  pix_ready,
        input  vga_address, vga_write, vga_writedata,
        output vga_waitrequest
    );

    modport slave (
        input  pal_we, pal_idx, pal_rgb,
        input  pix_valid, pix_index, pix_x, pix_y, pix_last,
        output pix_ready,
        output vga_address, vga_write, vga_writedata,
        input  vga_waitrequest
    );
endinterface

// File: rtl/doom_pal_writer.sv
// rtl/doom_pal_writer.sv - palette expansion, output FIFO and Avalon-MM pixel writer
// Optional off-screen clipping to null entries is enabled by defining DOOM_PAL_CLIP_EN.
module doom_pal_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] VGA_BASE   = 32'h0800_0000,
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SCREEN_H   = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    doom_pal_writer_if.slave bus,
    output logic             busy,
    output logic             frame_done
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("doom_pal_writer: FIFO_DEPTH must be a power of two of at least 2");
    end
    if ((SCREEN_W > 512) || (SCREEN_H > 256)) begin : g_bad_screen
        $error("doom_pal_writer: screen size exceeds the pix_x/pix_y coordinate range");
    end

    logic [15:0] pal_mem [256];
    logic [15:0] pal_wdata;
    logic        unused_rgb_lsbs;

    logic        ready_en;
    logic        accept;
    logic [31:0] pix_addr;

    logic        s1_valid;
    logic        s1_last;
    logic [31:0] s1_addr;
    logic [15:0] s1_data;

    logic [31:0] fifo_addr [FIFO_DEPTH];
    logic [15:0] fifo_data [FIFO_DEPTH];
    logic        fifo_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic        nonempty;
    logic        pop;

`ifdef DOOM_PAL_CLIP_EN
    logic        pix_null;
    logic        s1_null;
    logic        fifo_null [FIFO_DEPTH];
    logic        head_null;
`endif

    // RGB888 -> RGB565 keeps the top bits of each channel
    assign pal_wdata       = {bus.pal_rgb[23:19], bus.pal_rgb[15:10], bus.pal_rgb[7:3]};
    assign unused_rgb_lsbs = ^{bus.pal_rgb[18:16], bus.pal_rgb[9:8], bus.pal_rgb[2:0]};

    // Occupancy counts the lookup stage too, so every accepted pixel has a FIFO slot reserved
    assign bus.pix_ready = ready_en & ((count + CW'(s1_valid)) < CW'(FIFO_DEPTH));
    assign accept        = bus.pix_valid & bus.pix_ready;
    assign pix_addr      = VGA_BASE + ({24'd0, bus.pix_y} << 10) + ({23'd0, bus.pix_x} << 1);

`ifdef DOOM_PAL_CLIP_EN
    assign pix_null = ({23'd0, bus.pix_x} >= SCREEN_W) | ({24'd0, bus.pix_y} >= SCREEN_H);
`endif

    // Palette and lookup data are not reset; the read sees the pre-write entry on a collision
    always_ff @(posedge clk) begin
        if (bus.pal_we) begin
            pal_mem[bus.pal_idx] <= pal_wdata;
        end
        if (accept) begin
            s1_data <= pal_mem[bus.pix_index];
            s1_addr <= pix_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
`ifdef DOOM_PAL_CLIP_EN
            s1_null  <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_last <= bus.pix_last;
`ifdef DOOM_PAL_CLIP_EN
                s1_null <= pix_null;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            fifo_addr[wr_ptr] <= s1_addr;
            fifo_data[wr_ptr] <= s1_data;
            fifo_last[wr_ptr] <= s1_last;
`ifdef DOOM_PAL_CLIP_EN
            fifo_null[wr_ptr] <= s1_null;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s1_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(s1_valid) - CW'(pop);
        end
    end

    assign nonempty = (count != '0);

`ifdef DOOM_PAL_CLIP_EN
    // A null entry retires on its own in one cycle, never touching the bus
    assign head_null     = fifo_null[rd_ptr];
    assign bus.vga_write = nonempty & ~head_null;
    assign pop           = nonempty & (head_null | ~bus.vga_waitrequest);
`else
    assign bus.vga_write = nonempty;
    assign pop           = nonempty & ~bus.vga_waitrequest;
`endif

    assign bus.vga_address   = nonempty ? fifo_addr[rd_ptr] : '0;
    assign bus.vga_writedata = nonempty ? fifo_data[rd_ptr] : '0;
    assign frame_done        = pop & fifo_last[rd_ptr];
    assign busy              = s1_valid | nonempty;
endmodule

// File: tb/tb_doom_pal_writer.sv
// tb/tb_doom_pal_writer.sv - directed self-checking bench for doom_pal_writer
module tb_doom_pal_writer;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    logic frame_done;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    logic [31:0] q_addr[$];
    logic [15:0] q_data[$];
    int          q_cyc[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;

    doom_pal_writer_if bus ();

    doom_pal_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    // Records completed bus writes and frame_done pulses with the number of the edge that completes them
    always @(negedge clk) begin
        if (bus.vga_write && !bus.vga_waitrequest) begin
            q_addr.push_back(bus.vga_address);
            q_data.push_back(bus.vga_writedata);
            q_cyc.push_back(cycle + 1);
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cycle + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        fd_cnt = 0;
        fd_cyc = 0;
    endtask

    task automatic pal_load(input logic [7:0] idx, input logic [23:0] rgb);
        bus.pal_we  = 1'b1;
        bus.pal_idx = idx;
        bus.pal_rgb = rgb;
        tick();
        bus.pal_we  = 1'b0;
    endtask

    task automatic send(input logic [7:0] idx, input logic [8:0] x, input logic [7:0] y, input logic last);
        int n;
        n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_index = idx;
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.pix_last  = last;
        while (!bus.pix_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_accept", 64'(n < 50), 64'd1);
        tick();
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle", 64'(n < 100), 64'd1);
    endtask

    function automatic logic [15:0] pal_of(input int k);
        case (k % 3)
            0:       return 16'hFC08;
            1:       return 16'hFFFF;
            default: return 16'h11AA;
        endcase
    endfunction

    function automatic logic [7:0] idx_of(input int k);
        case (k % 3)
            0:       return 8'd5;
            1:       return 8'd7;
            default: return 8'd10;
        endcase
    endfunction

    initial begin
        int n_acc, n, stalls, i, p0, bad, unstable;
        logic rdy;
        logic [31:0] snap_a;
        logic [15:0] snap_d;

        reset_n             = 1'b0;
        bus.pal_we          = 1'b0;
        bus.pal_idx         = '0;
        bus.pal_rgb         = '0;
        bus.pix_valid       = 1'b0;
        bus.pix_index       = '0;
        bus.pix_x           = '0;
        bus.pix_y           = '0;
        bus.pix_last        = 1'b0;
        bus.vga_waitrequest = 1'b0;

        // reset state
        #12;
        chk("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
        chk("rst_vga_write", 64'(bus.vga_write), 64'd0);
        chk("rst_vga_address", 64'(bus.vga_address), 64'd0);
        chk("rst_vga_writedata", 64'(bus.vga_writedata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_before_first_clk", 64'(bus.pix_ready), 64'd0);
        tick();
        chk("ready_after_first_clk", 64'(bus.pix_ready), 64'd1);

        // palette conversion and two-cycle latency
        pal_load(8'd5, 24'hFF8040);
        clear_mon();
        send(8'd5, 9'd3, 8'd2, 1'b0);
        chk("lat_write_early", 64'(bus.vga_write), 64'd0);
        chk("lat_busy_s1", 64'(busy), 64'd1);
        tick();
        chk("lat_write", 64'(bus.vga_write), 64'd1);
        chk("lat_address", 64'(bus.vga_address), 64'(BASE + 32'h806));
        chk("lat_data", 64'(bus.vga_writedata), 64'hFC08);
        tick();
        chk("lat_write_done", 64'(bus.vga_write), 64'd0);
        chk("lat_busy_done", 64'(busy), 64'd0);
        chk("lat_count", 64'(q_addr.size()), 64'd1);

        // read during write of the same palette entry
        pal_load(8'd7, 24'h0000FF);
        clear_mon();
        bus.pal_we    = 1'b1;
        bus.pal_idx   = 8'd7;
        bus.pal_rgb   = 24'hFFFFFF;
        bus.pix_valid = 1'b1;
        bus.pix_index = 8'd7;
        bus.pix_x     = 9'd0;
        bus.pix_y     = 8'd0;
        bus.pix_last  = 1'b0;
        chk("rdw_ready", 64'(bus.pix_ready), 64'd1);
        tick();
        bus.pal_we    = 1'b0;
        bus.pix_valid = 1'b0;
        send(8'd7, 9'd1, 8'd0, 1'b0);
        wait_idle();
        chk("rdw_count", 64'(q_data.size()), 64'd2);
        if (q_data.size() == 2) begin
            chk("rdw_old_data", 64'(q_data[0]), 64'h001F);
            chk("rdw_new_data", 64'(q_data[1]), 64'hFFFF);
            chk("rdw_addr1", 64'(q_addr[1]), 64'(BASE + 32'h2));
        end

        // backpressure: 10 stalled cycles while 8 pixels are offered
        pal_load(8'd10, 24'h123456);
        clear_mon();
        bus.vga_waitrequest = 1'b1;
        n_acc = 0; n = 0; unstable = 0;
        snap_a = '0; snap_d = '0;
        bus.pix_valid = 1'b1;
        bus.pix_index = idx_of(0);
        bus.pix_x     = 9'd0;
        bus.pix_y     = 8'd0;
        while (n_acc < 8 && n < 200) begin
            rdy = bus.pix_ready;
            if (n == 10) bus.vga_waitrequest = 1'b0;
            tick();
            n++;
            if (rdy) begin
                n_acc++;
                if (n_acc == 4) chk("bp_ready_low_after_4", 64'(bus.pix_ready), 64'd0);
                if (n_acc < 8) begin
                    bus.pix_index = idx_of(n_acc);
                    bus.pix_x     = 9'(n_acc);
                    bus.pix_y     = 8'(n_acc);
                end else begin
                    bus.pix_valid = 1'b0;
                end
            end
            if (n == 2) begin
                snap_a = bus.vga_address;
                snap_d = bus.vga_writedata;
                chk("bp_stall_write", 64'(bus.vga_write), 64'd1);
            end else if (n > 2 && n <= 10) begin
                if (!bus.vga_write || bus.vga_address !== snap_a || bus.vga_writedata !== snap_d)
                    unstable++;
            end
        end
        bus.pix_valid = 1'b0;
        chk("bp_accepted", 64'(n_acc), 64'd8);
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_stall_addr", 64'(snap_a), 64'(BASE));
        wait_idle();
        chk("bp_count", 64'(q_addr.size()), 64'd8);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < q_addr.size()) begin
                if (q_addr[k] !== BASE + 32'(k * 1024 + k * 2) || q_data[k] !== pal_of(k)) bad++;
            end
        end
        chk("bp_order_data", 64'(bad), 64'd0);

        // off-screen pixel flagged last
        clear_mon();
        send(8'd5, 9'd320, 8'd0, 1'b1);
        wait_idle();
        tick();
        chk("clip_frame_done", 64'(fd_cnt), 64'd1);
`ifdef DOOM_PAL_CLIP_EN
        chk("clip_no_write", 64'(q_addr.size()), 64'd0);
`else
        chk("noclip_write", 64'(q_addr.size()), 64'd1);
        if (q_addr.size() == 1) begin
            chk("noclip_addr", 64'(q_addr[0]), 64'(BASE + 32'h280));
            chk("noclip_data", 64'(q_data[0]), 64'hFC08);
        end
`endif

        // sustained 320-pixel frame
        clear_mon();
        i = 0; n = 0; stalls = 0; p0 = 0;
        bus.pix_valid = 1'b1;
        bus.pix_index = idx_of(0);
        bus.pix_x     = 9'd0;
        bus.pix_y     = 8'd3;
        bus.pix_last  = 1'b0;
        while (i < 320 && n < 1000) begin
            rdy = bus.pix_ready;
            tick();
            n++;
            if (rdy) begin
                if (i == 0) p0 = cycle;
                i++;
                if (i < 320) begin
                    bus.pix_index = idx_of(i);
                    bus.pix_x     = 9'(i);
                    bus.pix_last  = (i == 319);
                end else begin
                    bus.pix_valid = 1'b0;
                    bus.pix_last  = 1'b0;
                end
            end else begin
                stalls++;
            end
        end
        chk("frame_stalls", 64'(stalls), 64'd0);
        tick();
        chk("frame_busy_before_last", 64'(busy), 64'd1);
        chk("frame_done_with_last", 64'(frame_done), 64'd1);
        tick();
        chk("frame_busy_after", 64'(busy), 64'd0);
        chk("frame_done_after", 64'(frame_done), 64'd0);
        chk("frame_count", 64'(q_addr.size()), 64'd320);
        chk("frame_fd_cnt", 64'(fd_cnt), 64'd1);
        chk("frame_fd_cyc", 64'(fd_cyc), 64'(p0 + 321));
        bad = 0;
        for (int k = 0; k < 320; k++) begin
            if (k < q_addr.size()) begin
                if (q_cyc[k] != p0 + 2 + k) bad++;
                if (q_addr[k] !== BASE + 32'(3 * 1024 + k * 2) || q_data[k] !== pal_of(k)) bad++;
            end
        end
        chk("frame_timing_data", 64'(bad), 64'd0);

        // reset with three entries buffered
        clear_mon();
        bus.vga_waitrequest = 1'b1;
        send(8'd5, 9'd0, 8'd0, 1'b0);
        send(8'd7, 9'd1, 8'd0, 1'b0);
        send(8'd10, 9'd2, 8'd0, 1'b1);
        tick();
        chk("mid_busy_before", 64'(busy), 64'd1);
        chk("mid_write_before", 64'(bus.vga_write), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_write_dropped", 64'(bus.vga_write), 64'd0);
        chk("mid_busy_dropped", 64'(busy), 64'd0);
        chk("mid_frame_done", 64'(frame_done), 64'd0);
        chk("mid_ready_low", 64'(bus.pix_ready), 64'd0);
        bus.vga_waitrequest = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        chk("mid_no_writes", 64'(q_addr.size()), 64'd0);
        chk("mid_no_fd", 64'(fd_cnt), 64'd0);
        send(8'd10, 9'd5, 8'd1, 1'b1);
        wait_idle();
        tick();
        chk("post_rst_count", 64'(q_addr.size()), 64'd1);
        if (q_addr.size() == 1) begin
            chk("post_rst_addr", 64'(q_addr[0]), 64'(BASE + 32'h40A));
            chk("post_rst_data", 64'(q_data[0]), 64'h11AA);
        end
        chk("post_rst_fd", 64'(fd_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
